// File: rtl/sram_ctrl_gen2_if.sv
// Requester-side bus of the asynchronous SRAM controller: one-cycle read/write
// strobes in, read data / completion pulses / ready handshake out.
interface sram_ctrl_gen2_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 16
) ();
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_rd_strt;
  logic              i_wr_strt;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_data;
  logic [BE_W-1:0]   i_be;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_wr_done;
  logic              o_ready;
  logic              o_busy;

  // Requester side
  modport master (
    output i_rd_strt, i_wr_strt, i_address, i_data, i_be,
    input  o_data, o_data_valid, o_wr_done, o_ready, o_busy
  );

  // Controller side
  modport slave (
    input  i_rd_strt, i_wr_strt, i_address, i_data, i_be,
    output o_data, o_data_valid, o_wr_done, o_ready, o_busy
  );
endinterface

// File: rtl/sram_ctrl_gen2.sv
// Parametrised asynchronous-SRAM controller. Turns single-cycle read/write
// strobes into timed CS/OE/WE/byte-lane sequences. Every output is registered;
// the next-state logic computes the value each output takes after the edge.
module sram_ctrl_gen2 #(
  parameter int unsigned ADDR_W         = 21,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned POWERUP_CYCLES = 40000,
  parameter int unsigned RD_WAIT        = 3,
  parameter int unsigned WR_WAIT        = 3,
  localparam int unsigned BE_W          = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              reset,
  sram_ctrl_gen2_if.slave   bus,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_CS,
  output logic              o_OE,
  output logic              o_WE,
  output logic [BE_W-1:0]   o_BE_n
);

  localparam int unsigned MaxWait =
    (POWERUP_CYCLES > RD_WAIT) ?
      ((POWERUP_CYCLES > WR_WAIT) ? POWERUP_CYCLES : WR_WAIT) :
      ((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT);
  localparam int unsigned CntW = $clog2(MaxWait + 1);

  typedef enum logic [2:0] {StInit, StIdle, StRead, StWrSetup, StWrite, StWrHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic              dq_oe_q, dq_oe_d;
  logic              cs_q, cs_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic [BE_W-1:0]   be_q, be_d;

  // Next state plus the registered value of every output after this edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    addr_d  = addr_q;
    dq_d    = dq_q;
    dq_oe_d = 1'b0;
    cs_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    be_n_d  = '1;
    be_d    = be_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == CntW'(POWERUP_CYCLES - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        // Read has priority; a simultaneous write strobe is dropped
        if (bus.i_rd_strt) begin
          state_d = StRead;
          addr_d  = bus.i_address;
          cnt_d   = '0;
          cs_d    = 1'b0;
          oe_d    = 1'b0;
          be_n_d  = '0;
        end else if (bus.i_wr_strt) begin
          state_d = StWrSetup;
          addr_d  = bus.i_address;
          dq_d    = bus.i_data;
          be_d    = bus.i_be;
          dq_oe_d = 1'b1;
          cs_d    = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      StRead: begin
        if (cnt_q == CntW'(RD_WAIT - 1)) begin
          // Pins are still low during this cycle, so the SRAM data is valid
          state_d = StIdle;
          cnt_d   = '0;
          data_d  = i_sram_dq;
          valid_d = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          cs_d   = 1'b0;
          oe_d   = 1'b0;
          be_n_d = '0;
        end
      end
      StWrSetup: begin
        state_d = StWrite;
        cnt_d   = '0;
        dq_oe_d = 1'b1;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        be_n_d  = ~be_q;
      end
      StWrite: begin
        dq_oe_d = 1'b1;
        if (cnt_q == CntW'(WR_WAIT - 1)) begin
          // WE/CS rise while data keeps being driven for hold time
          state_d = StWrHold;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          cs_d   = 1'b0;
          we_d   = 1'b0;
          be_n_d = ~be_q;
        end
      end
      StWrHold: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      be_n_q  <= '1;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      be_n_q  <= be_n_d;
      be_q    <= be_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_wr_done    = done_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_busy       = ~ready_q;
  assign o_sram_address   = addr_q;
  assign o_sram_dq        = dq_q;
  assign o_sram_dq_oe     = dq_oe_q;
  assign o_CS             = cs_q;
  assign o_OE             = oe_q;
  assign o_WE             = we_q;
  assign o_BE_n           = be_n_q;

endmodule

// File: tb/tb_sram_ctrl_gen2.sv
// Self-checking bench for sram_ctrl_gen2 with a small behavioural SRAM.
module tb_sram_ctrl_gen2;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;

  // Control bundle: {ready, busy, cs, oe, we, be_n[1:0], dq_oe, valid, done}
  localparam logic [9:0] C_INIT  = 10'b0_1_1_1_1_11_0_0_0;
  localparam logic [9:0] C_IDLE  = 10'b1_0_1_1_1_11_0_0_0;
  localparam logic [9:0] C_IDLEV = 10'b1_0_1_1_1_11_0_1_0;
  localparam logic [9:0] C_RD    = 10'b0_1_0_0_1_00_0_0_0;
  localparam logic [9:0] C_WSET  = 10'b0_1_0_1_1_11_1_0_0;
  localparam logic [9:0] C_WR11  = 10'b0_1_0_1_0_00_1_0_0;
  localparam logic [9:0] C_WR01  = 10'b0_1_0_1_0_10_1_0_0;
  localparam logic [9:0] C_WR10  = 10'b0_1_0_1_0_01_1_0_0;
  localparam logic [9:0] C_WHOLD = 10'b0_1_1_1_1_11_1_0_1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_dq;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_din;
  logic          cs, oe, we;
  logic [1:0]    be_n;
  logic [15:0]   mem [256];

  int checks = 0;
  int errors = 0;
  int mon_viol = 0;

  sram_ctrl_gen2_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_ctrl_gen2 #(
    .ADDR_W(AW), .DATA_W(DW), .POWERUP_CYCLES(8), .RD_WAIT(3), .WR_WAIT(3)
  ) dut (
    .i_clk          (clk),
    .reset          (reset),
    .bus            (bus),
    .o_sram_address (sram_address),
    .o_sram_dq      (sram_dq),
    .o_sram_dq_oe   (sram_dq_oe),
    .i_sram_dq      (sram_din),
    .o_CS           (cs),
    .o_OE           (oe),
    .o_WE           (we),
    .o_BE_n         (be_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM, low 8 address bits decoded
  always @(posedge clk) begin
    if (!cs && !we && sram_dq_oe) begin
      if (!be_n[0]) mem[sram_address[7:0]][7:0]  <= sram_dq[7:0];
      if (!be_n[1]) mem[sram_address[7:0]][15:8] <= sram_dq[15:8];
    end
  end
  assign sram_din = (!cs && !oe) ? mem[sram_address[7:0]] : 16'hDEAD;

  // Bus-turnaround and pulse-width monitor
  logic prev_oe = 1'b1, prev_dq_oe = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (sram_dq_oe && !oe) mon_viol++;
    if (sram_dq_oe && !prev_dq_oe && !prev_oe) mon_viol++;
    if (bus.o_data_valid && bus.o_wr_done) mon_viol++;
    if (bus.o_data_valid && prev_valid) mon_viol++;
    if (bus.o_wr_done && prev_done) mon_viol++;
    prev_oe    = oe;
    prev_dq_oe = sram_dq_oe;
    prev_valid = bus.o_data_valid;
    prev_done  = bus.o_wr_done;
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [9:0]  e_ctl;
    logic [20:0] e_addr;
    logic [15:0] e_dq;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rd, logic wr, logic [20:0] addr,
                              logic [15:0] wdata, logic [1:0] be, logic [9:0] e_ctl,
                              logic [20:0] e_addr, logic [15:0] e_dq, logic [15:0] e_data);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.e_ctl = e_ctl; v.e_addr = e_addr; v.e_dq = e_dq; v.e_data = e_data;
    return v;
  endfunction

  function automatic logic [9:0] ctl_now();
    return {bus.o_ready, bus.o_busy, cs, oe, we, be_n, sram_dq_oe, bus.o_data_valid,
            bus.o_wr_done};
  endfunction

  function automatic logic [62:0] rst_now();
    return {bus.o_data, bus.o_data_valid, bus.o_wr_done, bus.o_ready, bus.o_busy,
            sram_address, sram_dq, sram_dq_oe, cs, oe, we, be_n};
  endfunction

  localparam logic [62:0] RST_EXP = {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 21'h0, 16'h0, 1'b0,
                                     3'b111, 2'b11};

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rd, logic wr, logic [20:0] addr, logic [15:0] wdata,
                       logic [1:0] be);
    bus.i_rd_strt = rd;
    bus.i_wr_strt = wr;
    bus.i_address = addr;
    bus.i_data    = wdata;
    bus.i_be      = be;
  endtask

  // Counts edges until ready rises; SRAM pins must stay idle meanwhile
  task automatic wait_ready(string name, int exp_edges);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (bus.o_ready) begin
        seen = 1'b1;
        n    = i;
      end else begin
        check({name, "_inactive"}, 128'(ctl_now()), 128'(C_INIT));
      end
    end
    check({name, "_edges"}, 128'(n), 128'(exp_edges));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    // Reset with both strobes high; then power-up with a read strobe every cycle
    reset = 1'b1;
    drive(1'b1, 1'b1, 21'h1F, 16'h1111, 2'b11);
    step();
    step();
    check("reset_vals", 128'(rst_now()), 128'(RST_EXP));
    reset = 1'b0;
    wait_ready("powerup", 8);
    drive(1'b0, 1'b0, 21'h0, 16'h0, 2'b00);

    // Per-cycle table: inputs applied before an edge, outputs expected after it
    vecs.push_back(mk("wA_setup", 0, 1, 21'h1ABCD, 16'hBEEF, 2'b11, C_WSET, 21'h1ABCD, 16'hBEEF, 16'h0));
    vecs.push_back(mk("wA_we1",   0, 0, 21'h0, 16'h0, 2'b00, C_WR11, 21'h1ABCD, 16'hBEEF, 16'h0));
    vecs.push_back(mk("wA_we2",   0, 1, 21'h5, 16'h1111, 2'b11, C_WR11, 21'h1ABCD, 16'hBEEF, 16'h0));
    vecs.push_back(mk("wA_we3",   1, 0, 21'h5, 16'h0, 2'b00, C_WR11, 21'h1ABCD, 16'hBEEF, 16'h0));
    vecs.push_back(mk("wA_hold",  0, 0, 21'h0, 16'h0, 2'b00, C_WHOLD, 21'h1ABCD, 16'hBEEF, 16'h0));
    vecs.push_back(mk("wA_idle",  0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h1ABCD, 16'h0, 16'h0));
    vecs.push_back(mk("rA_1",     1, 0, 21'h1ABCD, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'h0));
    vecs.push_back(mk("rA_2",     0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'h0));
    vecs.push_back(mk("rA_3",     0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'h0));
    vecs.push_back(mk("rA_valid", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLEV, 21'h1ABCD, 16'h0, 16'hBEEF));
    vecs.push_back(mk("rA_held",  0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h1ABCD, 16'h0, 16'hBEEF));
    vecs.push_back(mk("w5f_setup", 0, 1, 21'h5, 16'hFFFF, 2'b11, C_WSET, 21'h5, 16'hFFFF, 16'hBEEF));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("w5f_we", 0, 0, 21'h0, 16'h0, 2'b00, C_WR11, 21'h5, 16'hFFFF, 16'hBEEF));
    vecs.push_back(mk("w5f_hold", 0, 0, 21'h0, 16'h0, 2'b00, C_WHOLD, 21'h5, 16'hFFFF, 16'hBEEF));
    vecs.push_back(mk("w5f_idle", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h5, 16'h0, 16'hBEEF));
    vecs.push_back(mk("w5l_setup", 0, 1, 21'h5, 16'h1234, 2'b01, C_WSET, 21'h5, 16'h1234, 16'hBEEF));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("w5l_we_lb", 0, 0, 21'h0, 16'h0, 2'b00, C_WR01, 21'h5, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("w5l_hold", 0, 0, 21'h0, 16'h0, 2'b00, C_WHOLD, 21'h5, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("w5l_idle", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h5, 16'h0, 16'hBEEF));
    vecs.push_back(mk("both_rd1", 1, 1, 21'h5, 16'hAAAA, 2'b11, C_RD, 21'h5, 16'h0, 16'hBEEF));
    vecs.push_back(mk("both_rd2", 0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h5, 16'h0, 16'hBEEF));
    vecs.push_back(mk("both_rd3", 0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h5, 16'h0, 16'hBEEF));
    vecs.push_back(mk("r5_valid", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLEV, 21'h5, 16'h0, 16'hFF34));
    vecs.push_back(mk("wAu_setup", 0, 1, 21'h1ABCD, 16'h5A5A, 2'b10, C_WSET, 21'h1ABCD, 16'h5A5A, 16'hFF34));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("wAu_we_ub", 0, 0, 21'h0, 16'h0, 2'b00, C_WR10, 21'h1ABCD, 16'h5A5A, 16'hFF34));
    vecs.push_back(mk("wAu_hold", 0, 0, 21'h0, 16'h0, 2'b00, C_WHOLD, 21'h1ABCD, 16'h5A5A, 16'hFF34));
    vecs.push_back(mk("wAu_idle", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h1ABCD, 16'h0, 16'hFF34));
    vecs.push_back(mk("rA2_1", 1, 0, 21'h1ABCD, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'hFF34));
    vecs.push_back(mk("rA2_2", 0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'hFF34));
    vecs.push_back(mk("rA2_3", 0, 0, 21'h0, 16'h0, 2'b00, C_RD, 21'h1ABCD, 16'h0, 16'hFF34));
    vecs.push_back(mk("rA2_valid", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLEV, 21'h1ABCD, 16'h0, 16'h5AEF));
    vecs.push_back(mk("rA2_held", 0, 0, 21'h0, 16'h0, 2'b00, C_IDLE, 21'h1ABCD, 16'h0, 16'h5AEF));

    foreach (vecs[i]) begin
      logic [15:0] dq_act;
      logic [15:0] dq_exp;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      step();
      dq_act = vecs[i].e_ctl[2] ? sram_dq : 16'h0;
      dq_exp = vecs[i].e_ctl[2] ? vecs[i].e_dq : 16'h0;
      check(vecs[i].name, 128'({ctl_now(), sram_address, bus.o_data, dq_act}),
            128'({vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_data, dq_exp}));
    end

    // Reset during the second WE-low cycle aborts the write
    drive(1'b0, 1'b1, 21'h77, 16'h1357, 2'b11);
    step();
    drive(1'b0, 1'b0, 21'h0, 16'h0, 2'b00);
    step();
    step();
    check("abort_pre", 128'(ctl_now()), 128'(C_WR11));
    reset = 1'b1;
    step();
    check("abort_reset", 128'(rst_now()), 128'(RST_EXP));
    reset = 1'b0;
    drive(1'b1, 1'b0, 21'h77, 16'h0, 2'b00);
    wait_ready("reinit", 8);
    drive(1'b0, 1'b0, 21'h0, 16'h0, 2'b00);
    step();

    check("monitor_viol", 128'(mon_viol), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
